mem_port_arbiter: RTL

Arbiter and sequencer for a single-port synchronous memory shared by the pipeline's instruction-fetch port and MEM-stage data port. It grants one requester at a time, drives the memory for exactly one access cycle, waits the memory's fixed read latency, and returns registered data with a one-cycle acknowledge. The stall outputs feed the hazard logic so that IF or MEM freezes while its request is pending.

---
 rtl/mem_port_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// instruction-fetch port and the MEM-stage data port. Data has priority.
// Every transaction runs ISSUE (one mem_en cycle), LAT WAIT cycles, then
// DONE (one-cycle ack), so all transactions take LAT+3 cycles.
// Build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive lost
// arbitrations, a pending fetch is granted ahead of data.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 19,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // LAT is at most 15, so LAT-1 always fits in four bits
    localparam int CNT_W = 4;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              own_data_q, own_data_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              fetch_wins;
    logic              flush_now;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int LOSE_W = $clog2(STARVE_MAX + 1);
    logic [LOSE_W-1:0] lose_cnt_q, lose_cnt_d;

    // Fetch wins when alone, or once it has lost STARVE_MAX grants in a row
    assign fetch_wins = if_req & (~d_req | (lose_cnt_q == LOSE_W'(STARVE_MAX)));

    // Count IDLE grants taken by data while a fetch was waiting
    always_comb begin
        lose_cnt_d = lose_cnt_q;
        if (state_q == IDLE && (if_req | d_req)) begin
            if (fetch_wins)
                lose_cnt_d = '0;
            else if (if_req)
                lose_cnt_d = lose_cnt_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lose_cnt_q <= '0;
        else
            lose_cnt_q <= lose_cnt_d;
    end
`else
    assign fetch_wins = if_req & ~d_req;
`endif

    // A flush seen in this or any earlier cycle of a fetch transaction
    assign flush_now = flush_q | (~own_data_q & if_flush);

    // Next-state and next-output logic for the transaction sequencer
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_data_d = own_data_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        flush_d    = flush_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (if_req | d_req) begin
                    state_d    = ISSUE;
                    own_data_d = ~fetch_wins;
                    flush_d    = 1'b0;
                    mem_en_d   = 1'b1;
                    if (fetch_wins) begin
                        addr_d = if_addr;
                        we_d   = 1'b0;
                    end else begin
                        addr_d   = d_addr;
                        we_d     = d_we;
                        wdata_d  = d_wdata;
                        mem_we_d = d_we;
                    end
                end
            end
            ISSUE: begin
                flush_d = flush_now;
                cnt_d   = CNT_W'(LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                flush_d = flush_now;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (own_data_q) begin
                        d_ack_d = 1'b1;
                        if (!we_q)
                            d_rdata_d = mem_rdata;
                    end else if (!flush_now) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            flush_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_data_q <= own_data_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            flush_q    <= flush_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
        end
    end

    // A flush arriving in the DONE cycle still cancels the fetch ack
    assign if_ack    = if_ack_q & ~if_flush;
    assign d_ack     = d_ack_q;
    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != IDLE);

endmodule
